// File: rtl/sound_request_arbiter.sv
// Round-robin arbiter for sound-trigger requests feeding a small ID FIFO
// that the CPU reads and pops over an 8-bit Avalon-MM slave.
//
// Ports:
//   clk, reset_n       clock, async active-low reset
//   req, req_id        per-requester level request and packed sound IDs
//   req_grant          one-cycle one-hot grant pulse
//   address, chipselect, write_n, writedata, readdata
//                      Avalon-MM slave (1-cycle registered read)
//   sound_id_out       registered FIFO head ID (0 when empty)
//   sound_valid        registered FIFO non-empty flag
//   irq                irq_en & sound_valid
module sound_request_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*ID_W-1:0] req_id,
    output logic [NUM_REQ-1:0]      req_grant,
    input  logic [1:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [7:0]              writedata,
    output logic [7:0]              readdata,
    output logic [ID_W-1:0]         sound_id_out,
    output logic                    sound_valid,
    output logic                    irq
);

    localparam int RW = $clog2(NUM_REQ);
    localparam int IW = RW + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [IW-1:0] NREQ_C  = IW'(NUM_REQ);

    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [RW-1:0]      rr_q, rr_d;
    logic [ID_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               valid_q, valid_d;
    logic               irq_en_q, irq_en_d;
    logic [7:0]         rdata_q, rdata_d;

    logic               wr;
    logic               pop;
    logic               flush;
    logic               enq;
    logic               found;
    logic               grant_ok;
    logic [NUM_REQ-1:0] elig;
    logic [RW-1:0]      win;
    logic [ID_W-1:0]    win_id;
    logic [IW-1:0]      idx;

    always_comb begin
        wr    = chipselect & ~write_n;
        pop   = wr && (address == 2'd2) && (count_q != '0);
        flush = wr && (address == 2'd3) && writedata[0];

        // A requester still seeing its grant pulse is masked so the
        // cycle in which it drops req cannot win a second time.
        elig  = req & ~grant_q;

        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_q} + IW'(k);
            if (idx >= NREQ_C) begin
                idx = idx - NREQ_C;
            end
            if (!found && elig[idx[RW-1:0]]) begin
                found = 1'b1;
                win   = idx[RW-1:0];
            end
        end

        grant_ok = found && (count_q < DEPTH_C) && !flush;

        grant_d = '0;
        win_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (RW'(i) == win) begin
                win_id = req_id[i*ID_W +: ID_W];
            end
            grant_d[i] = grant_ok && (RW'(i) == win);
        end

        // ID 0 means "no sound": granted, never queued.
        enq = grant_ok && (win_id != '0);

        rr_d = rr_q;
        if (grant_ok) begin
            rr_d = (win == RW'(NUM_REQ - 1)) ? '0 : win + RW'(1);
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(pop);
            tail_d  = tail_q + PW'(enq);
            count_d = count_q + CW'(enq) - CW'(pop);
        end

        // Bypass the entry being written when it becomes the head.
        if (count_d == '0) begin
            id_d = '0;
        end else if (enq && (head_d == tail_q)) begin
            id_d = win_id;
        end else begin
            id_d = mem_q[head_d];
        end
        valid_d = (count_d != '0);

        irq_en_d = irq_en_q;
        if (wr && (address == 2'd3)) begin
            irq_en_d = writedata[1];
        end

        rdata_d = '0;
        if (chipselect) begin
            unique case (address)
                2'd0: rdata_d[ID_W-1:0] = id_q;
                2'd1: begin
                    rdata_d[7:4] = 4'(count_q);
                    rdata_d[1]   = (count_q == DEPTH_C);
                    rdata_d[0]   = (count_q == '0);
                end
                2'd3: rdata_d[1] = irq_en_q;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q  <= '0;
            rr_q     <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            id_q     <= '0;
            valid_q  <= 1'b0;
            irq_en_q <= 1'b0;
            rdata_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            id_q     <= id_d;
            valid_q  <= valid_d;
            irq_en_q <= irq_en_d;
            rdata_q  <= rdata_d;
            if (enq) begin
                mem_q[tail_q] <= win_id;
            end
        end
    end

    assign req_grant    = grant_q;
    assign readdata     = rdata_q;
    assign sound_id_out = id_q;
    assign sound_valid  = valid_q;
    assign irq          = irq_en_q & valid_q;

endmodule

// File: tb/tb_sound_request_arbiter.sv
// Bench for sound_request_arbiter: queue-based reference model compared
// every cycle, plus hand-computed literal checks along directed scenarios.
module tb_sound_request_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] req_id;
    logic [3:0]  req_grant;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic [3:0]  sound_id_out;
    logic        sound_valid;
    logic        irq;
    logic        auto_drop;

    int n_cmp = 0;
    int n_bad = 0;

    sound_request_arbiter #(
        .NUM_REQ(4), .ID_W(4), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req(req), .req_id(req_id), .req_grant(req_grant),
        .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .sound_id_out(sound_id_out),
        .sound_valid(sound_valid), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: pending IDs as a queue, plain round-robin search.
    int unsigned q[$];
    logic [3:0]  m_grant = '0;
    int          m_rr = 0;
    logic        m_irq_en = 1'b0;
    logic [7:0]  m_rd = '0;
    int          s_sz;
    int          s_win;
    int          s_i;
    int unsigned s_id;
    logic        s_wr, s_pop, s_flush;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_grant  = '0;
            m_rr     = 0;
            m_irq_en = 1'b0;
            m_rd     = '0;
        end else begin
            s_sz    = q.size();
            s_wr    = chipselect && !write_n;
            s_pop   = s_wr && address == 2'd2 && s_sz > 0;
            s_flush = s_wr && address == 2'd3 && writedata[0];
            m_rd = 8'h00;
            if (chipselect) begin
                if (address == 2'd0) m_rd = (s_sz > 0) ? 8'(q[0]) : 8'h00;
                if (address == 2'd1) m_rd = 8'(s_sz * 16 + (s_sz == 4 ? 2 : 0) + (s_sz == 0 ? 1 : 0));
                if (address == 2'd3) m_rd = m_irq_en ? 8'h02 : 8'h00;
            end
            s_win = -1;
            if (s_sz < 4 && !s_flush) begin
                for (int k = 0; k < 4; k++) begin
                    s_i = (m_rr + k) % 4;
                    if (s_win < 0 && req[s_i] && !m_grant[s_i]) s_win = s_i;
                end
            end
            m_grant = '0;
            if (s_pop) void'(q.pop_front());
            if (s_win >= 0) begin
                m_grant[s_win] = 1'b1;
                m_rr = (s_win + 1) % 4;
                s_id = (req_id >> (4 * s_win)) & 16'h000f;
                if (s_id != 0) q.push_back(s_id);
            end
            if (s_flush) q.delete();
            if (s_wr && address == 2'd3) m_irq_en = writedata[1];
        end
    end

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [7:0] e_id;
    logic       e_valid;
    always @(negedge clk) begin
        e_valid = (q.size() > 0);
        e_id    = e_valid ? 8'(q[0]) : 8'h00;
        chk("m_grant", 8'(req_grant), 8'(m_grant));
        chk("m_id", 8'(sound_id_out), e_id);
        chk("m_valid", 8'(sound_valid), 8'(e_valid));
        chk("m_irq", 8'(irq), 8'(m_irq_en && e_valid));
        chk("m_rdata", readdata, m_rd);
    end

    task automatic tick();
        @(negedge clk);
        #1;
        if (auto_drop) req = req & ~req_grant;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic rd(input logic [1:0] a);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        tick();
        chipselect = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; req = '0; req_id = '0; address = '0;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        auto_drop = 1'b0;
        repeat (3) tick();
        chk("rst_grant", 8'(req_grant), 8'h00);
        chk("rst_valid", 8'(sound_valid), 8'h00);
        chk("rst_id", 8'(sound_id_out), 8'h00);
        chk("rst_irq", 8'(irq), 8'h00);
        chk("rst_rdata", readdata, 8'h00);
        reset_n = 1'b1;
        tick();
        rd(2'd1);
        chk("rd_empty", readdata, 8'h01);

        // single request, held through its grant pulse
        req_id = 16'h0500; req = 4'b0100;
        tick();
        chk("g2_grant", 8'(req_grant), 8'h04);
        chk("g2_valid", 8'(sound_valid), 8'h01);
        chk("g2_id", 8'(sound_id_out), 8'h05);
        tick();
        chk("g2_mask", 8'(req_grant), 8'h00);
        req = '0;
        tick();
        chk("g2_none", 8'(req_grant), 8'h00);
        chk("g2_id2", 8'(sound_id_out), 8'h05);

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // fill the FIFO round-robin
        req_id = 16'h4321; req = 4'hf; auto_drop = 1'b1;
        tick(); chk("rr_g0", 8'(req_grant), 8'h01);
        tick(); chk("rr_g1", 8'(req_grant), 8'h02);
        tick(); chk("rr_g2", 8'(req_grant), 8'h04);
        tick(); chk("rr_g3", 8'(req_grant), 8'h08);
        chk("rr_head", 8'(sound_id_out), 8'h01);
        rd(2'd1);
        chk("rd_full", readdata, 8'h42);

        // full: new request stalls until a pop frees a slot
        req_id = 16'h4327; req = 4'b0001;
        tick(); chk("full_g_a", 8'(req_grant), 8'h00);
        tick(); chk("full_g_b", 8'(req_grant), 8'h00);
        wr(2'd2, 8'h00);
        chk("pop1_g", 8'(req_grant), 8'h00);
        chk("pop1_id", 8'(sound_id_out), 8'h02);
        wr(2'd2, 8'h00);
        chk("pop2_g", 8'(req_grant), 8'h01);
        chk("pop2_id", 8'(sound_id_out), 8'h03);
        wr(2'd2, 8'h00);
        chk("pop3_id", 8'(sound_id_out), 8'h04);
        rd(2'd1);
        chk("rd_cnt2", readdata, 8'h20);

        // flush, pop while empty, then an ID-0 request
        wr(2'd3, 8'h01);
        chk("flush_valid", 8'(sound_valid), 8'h00);
        wr(2'd2, 8'h00);
        req_id = 16'h0000; req = 4'b0010;
        tick();
        chk("id0_grant", 8'(req_grant), 8'h02);
        chk("id0_valid", 8'(sound_valid), 8'h00);
        rd(2'd1);
        chk("id0_rd", readdata, 8'h01);

        // interrupt enable, then flush keeps irq_en
        wr(2'd3, 8'h02);
        req_id = 16'h0900; req = 4'b0100;
        tick();
        chk("irq_on", 8'(irq), 8'h01);
        chk("irq_id", 8'(sound_id_out), 8'h09);
        wr(2'd3, 8'h03);
        chk("irq_off", 8'(irq), 8'h00);
        chk("irq_valid", 8'(sound_valid), 8'h00);
        rd(2'd3);
        chk("rd_irqen", readdata, 8'h02);

        // refill, then asynchronous reset mid-cycle
        req_id = 16'h0063; req = 4'b0011;
        tick();
        chk("rf_g0", 8'(req_grant), 8'h01);
        tick();
        chk("rf_g1", 8'(req_grant), 8'h02);
        chk("rf_irq", 8'(irq), 8'h01);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_grant", 8'(req_grant), 8'h00);
        chk("arst_valid", 8'(sound_valid), 8'h00);
        chk("arst_id", 8'(sound_id_out), 8'h00);
        chk("arst_irq", 8'(irq), 8'h00);
        req = '0;
        tick();
        reset_n = 1'b1;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
